// File: rtl/voice_mixer.sv
// Voice mixer: on each accepted sample tick, reads one wavetable sample per active
// voice (one BRAM read per cycle) and emits their signed sum as a single mixed sample.
module voice_mixer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_NOTES    = 24,
  parameter int NUM_VOICES   = 8,
  parameter int IDX_WIDTH    = 5,
  parameter int BRAM_LATENCY = 2,
  parameter int MIX_WIDTH    = SAMPLE_WIDTH + $clog2(NUM_VOICES)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    sample_tick_in,
  input  logic [ADDR_WIDTH-1:0]   addr_in [NUM_NOTES],
  input  logic [3:0]              num_voices_in,
  input  logic [IDX_WIDTH-1:0]    active_voices_idx_in [NUM_VOICES],
  output logic [ADDR_WIDTH-1:0]   bram_addr_out,
  input  logic [SAMPLE_WIDTH-1:0] bram_data_in,
  output logic [MIX_WIDTH-1:0]    mix_out,
  output logic                    mix_valid_out,
  output logic                    busy_out,
  output logic                    overrun_out,
  output logic [1:0]              state_dbg_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int                    SLOT_W   = $clog2(NUM_VOICES);
  localparam logic [3:0]            MAX_N    = 4'(NUM_VOICES);
  localparam logic [IDX_WIDTH-1:0]  NOTE_LIM = IDX_WIDTH'(NUM_NOTES);
  localparam logic [BRAM_LATENCY-1:0] TAG_TOP = BRAM_LATENCY'(1) << (BRAM_LATENCY - 1);

  state_t                  r_state, w_next_state;
  logic [ADDR_WIDTH-1:0]   r_addr [NUM_NOTES];
  logic [IDX_WIDTH-1:0]    r_idx  [NUM_VOICES];
  logic [3:0]              r_n;
  logic [3:0]              r_slot;
  logic [ADDR_WIDTH-1:0]   r_bram_addr;
  logic [BRAM_LATENCY-1:0] r_tag_v;
  logic [BRAM_LATENCY-1:0] r_tag_z;
  logic [MIX_WIDTH-1:0]    r_acc;
  logic [MIX_WIDTH-1:0]    r_mix;
  logic                    r_mix_valid;

  logic [3:0]              w_n;
  logic                    w_tick_ok;
  logic [IDX_WIDTH-1:0]    w_first_idx;
  logic [ADDR_WIDTH-1:0]   w_first_addr;
  logic [IDX_WIDTH-1:0]    w_slot_idx;
  logic                    w_issue;
  logic                    w_issue_zero;
  logic [3:0]              w_next_slot;
  logic [IDX_WIDTH-1:0]    w_next_idx;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic                    w_last_slot;
  logic                    w_ret_live;
  logic [MIX_WIDTH-1:0]    w_sample_ext;
  logic [MIX_WIDTH-1:0]    w_acc_next;

  assign w_n          = (num_voices_in > MAX_N) ? MAX_N : num_voices_in;
  assign w_tick_ok    = sample_tick_in && (r_state == S_IDLE);
  // The first address is taken from the live inputs so slot 0 is on the bus at T+1.
  assign w_first_idx  = active_voices_idx_in[0];
  assign w_first_addr = (w_first_idx < NOTE_LIM) ? addr_in[w_first_idx] : '0;
  assign w_slot_idx   = r_idx[r_slot[SLOT_W-1:0]];
  assign w_issue      = (r_state == S_ISSUE);
  assign w_issue_zero = (w_slot_idx >= NOTE_LIM);
  assign w_next_slot  = r_slot + 4'd1;
  assign w_next_idx   = r_idx[w_next_slot[SLOT_W-1:0]];
  assign w_next_addr  = (w_next_idx < NOTE_LIM) ? r_addr[w_next_idx] : '0;
  assign w_last_slot  = (r_slot == r_n - 4'd1);
  // Oldest tag bit lines up with the data currently returning from the BRAM.
  assign w_ret_live   = r_tag_v[BRAM_LATENCY-1] && !r_tag_z[BRAM_LATENCY-1];
  assign w_sample_ext = {{(MIX_WIDTH-SAMPLE_WIDTH){bram_data_in[SAMPLE_WIDTH-1]}}, bram_data_in};
  assign w_acc_next   = r_acc + (w_ret_live ? w_sample_ext : '0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (sample_tick_in) w_next_state = (w_n != 4'd0) ? S_ISSUE : S_DONE;
      S_ISSUE: if (w_last_slot) w_next_state = S_DRAIN;
      // Leave once the only outstanding tag (if any) is the one returning now.
      S_DRAIN: if ((r_tag_v & ~TAG_TOP) == '0) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_addr      <= '{default: '0};
      r_idx       <= '{default: '0};
      r_n         <= '0;
      r_slot      <= '0;
      r_bram_addr <= '0;
      r_tag_v     <= '0;
      r_tag_z     <= '0;
      r_acc       <= '0;
      r_mix       <= '0;
      r_mix_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_mix_valid <= (w_next_state == S_DONE);
      r_tag_v     <= (r_tag_v << 1) | BRAM_LATENCY'(w_issue);
      r_tag_z     <= (r_tag_z << 1) | BRAM_LATENCY'(w_issue && w_issue_zero);
      r_acc       <= w_tick_ok ? '0 : w_acc_next;
      if (w_tick_ok) begin
        r_addr <= addr_in;
        r_idx  <= active_voices_idx_in;
        r_n    <= w_n;
        r_slot <= '0;
        if (w_n != 4'd0) r_bram_addr <= w_first_addr;
      end
      if (w_issue) begin
        r_slot <= w_next_slot;
        if (!w_last_slot) r_bram_addr <= w_next_addr;
      end
      if (w_next_state == S_DONE) r_mix <= (r_state == S_IDLE) ? '0 : w_acc_next;
    end
  end

  assign bram_addr_out = r_bram_addr;
  assign mix_out       = r_mix;
  assign mix_valid_out = r_mix_valid;
  assign busy_out      = (r_state != S_IDLE);
  assign overrun_out   = sample_tick_in && (r_state != S_IDLE);
  assign state_dbg_out = r_state;

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: wavetable BRAM model, expected-mix scoreboard with latency
// tracking, directed cases for reset/N=0/overrun/empty slots/clamping plus random mixes.
module tb_voice_mixer;
  localparam int AW  = 8;
  localparam int SW  = 8;
  localparam int NN  = 24;
  localparam int NV  = 8;
  localparam int IW  = 5;
  localparam int LAT = 2;
  localparam int MW  = 11;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n_in;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          sample_tick_in;
  logic [AW-1:0] addr_in [NN];
  logic [3:0]    num_voices_in;
  logic [IW-1:0] idx_in [NV];
  logic [AW-1:0] bram_addr_out;
  logic [SW-1:0] bram_data_in;
  logic [MW-1:0] mix_out;
  logic          mix_valid_out, busy_out, overrun_out;
  logic [1:0]    state_dbg_out;

  voice_mixer dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .sample_tick_in(sample_tick_in),
    .addr_in(addr_in), .num_voices_in(num_voices_in), .active_voices_idx_in(idx_in),
    .bram_addr_out(bram_addr_out), .bram_data_in(bram_data_in), .mix_out(mix_out),
    .mix_valid_out(mix_valid_out), .busy_out(busy_out), .overrun_out(overrun_out),
    .state_dbg_out(state_dbg_out)
  );

  // wavetable BRAM model, LAT = 2 cycles from address to data
  logic [SW-1:0] wave [256];
  logic [AW-1:0] p0 = '0, p1 = '0;
  always @(posedge clk) begin
    p0 <= bram_addr_out;
    p1 <= p0;
  end
  assign bram_data_in = wave[p1];

  // scoreboard
  logic [MW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [MW-1:0] last_exp = '0;
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n_in === 1'b1 && mix_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 1, 0);
      end else begin
        check_eq("mix_out", mix_out, exp_q.pop_front());
        check_eq("mix_latency", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic scramble();
    for (int k = 0; k < NV; k++) idx_in[k] = IW'($urandom_range(0, 31));
    for (int k = 0; k < NN; k++) addr_in[k] = AW'($urandom_range(0, 255));
  endtask

  task automatic start_mix(input int n_raw);
    int n, s;
    n = (n_raw > NV) ? NV : n_raw;
    s = 0;
    for (int k = 0; k < n; k++)
      if (idx_in[k] < NN) s += $signed(wave[addr_in[idx_in[k]]]);
    @(posedge clk); #1;
    num_voices_in  = 4'(n_raw);
    sample_tick_in = 1'b1;
    last_exp = MW'(s);
    exp_q.push_back(MW'(s));
    exp_cyc_q.push_back(cyc + ((n == 0) ? 1 : n + LAT + 1));
    @(posedge clk); #1;
    sample_tick_in = 1'b0;
    scramble();
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check_eq("done_in_time", (exp_q.size() == 0), 1);
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    check_eq("mix_hold", mix_out, last_exp);
    check_eq("idle_busy", busy_out, 0);
  endtask

  initial begin
    rst_n_in = 1'b0;
    sample_tick_in = 1'b0;
    num_voices_in = '0;
    for (int k = 0; k < NV; k++) idx_in[k] = '0;
    for (int k = 0; k < NN; k++) addr_in[k] = '0;
    for (int k = 0; k < 256; k++) wave[k] = SW'($urandom_range(0, 255));
    wave[0] = 8'd99;

    // reset state
    @(negedge clk);
    check_eq("rst_addr", bram_addr_out, 0);
    check_eq("rst_mix", mix_out, 0);
    check_eq("rst_valid", mix_valid_out, 0);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_overrun", overrun_out, 0);
    @(posedge clk); #1;
    rst_n_in = 1'b1;

    // N=3 directed case
    addr_in[2] = 8'd10; addr_in[5] = 8'd20; addr_in[9] = 8'd30;
    idx_in[0] = 5'd2; idx_in[1] = 5'd5; idx_in[2] = 5'd9;
    wave[10] = 8'sd5; wave[20] = -8'sd3; wave[30] = 8'sd7;
    start_mix(3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("n3_addr", bram_addr_out, (k == 0) ? 10 : (k == 1) ? 20 : 30);
    end
    wait_done();
    check_eq("n3_sum", last_exp, 9);

    // N=0, plus a tick landing in DONE
    start_mix(0);
    sample_tick_in = 1'b1;
    num_voices_in = 4'd3;
    @(negedge clk);
    check_eq("n0_busy", busy_out, 1);
    check_eq("done_overrun", overrun_out, 1);
    @(posedge clk); #1;
    sample_tick_in = 1'b0;
    @(negedge clk);
    check_eq("n0_busy_drop", busy_out, 0);
    wait_done();

    // full-scale negative and positive
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NV; k++) begin
        idx_in[k] = IW'(k);
        addr_in[k] = AW'(100 + k);
        wave[100 + k] = (pass == 0) ? 8'h80 : 8'h7f;
      end
      start_mix(8);
      wait_done();
    end

    // overrun at T+2, then a fresh tick is accepted
    for (int k = 0; k < NV; k++) idx_in[k] = IW'($urandom_range(0, 23));
    start_mix(3);
    @(posedge clk); #1;
    sample_tick_in = 1'b1;
    num_voices_in = 4'd8;
    @(negedge clk);
    check_eq("overrun_pulse", overrun_out, 1);
    @(posedge clk); #1;
    sample_tick_in = 1'b0;
    @(negedge clk);
    check_eq("overrun_clear", overrun_out, 0);
    wait_done();
    start_mix(2);
    wait_done();

    // empty slot contributes nothing and reads address 0
    idx_in[0] = 5'd4; idx_in[1] = 5'd31;
    addr_in[4] = 8'd50; wave[50] = 8'sd33;
    start_mix(2);
    @(negedge clk);
    check_eq("slot0_addr", bram_addr_out, 50);
    @(negedge clk);
    check_eq("empty_slot_addr", bram_addr_out, 0);
    wait_done();

    // count clamps to NUM_VOICES
    for (int k = 0; k < NV; k++) idx_in[k] = IW'($urandom_range(0, 23));
    start_mix(12);
    wait_done();

    // random mixes
    for (int r = 0; r < 10; r++) begin
      scramble();
      start_mix($urandom_range(0, 15));
      wait_done();
    end

    // asynchronous reset in the middle of ISSUE
    start_mix(5);
    @(posedge clk); #3;
    rst_n_in = 1'b0;
    #1;
    check_eq("arst_addr", bram_addr_out, 0);
    check_eq("arst_mix", mix_out, 0);
    check_eq("arst_busy", busy_out, 0);
    check_eq("arst_valid", mix_valid_out, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_mix", mix_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
